// File: rtl/wr_control_pkg.sv
// Shared constants for the output-memory write controller: default array size,
// lane address width and FSM state encoding.
package wr_control_pkg;

    localparam int WH_DEFAULT = 16;
    localparam int LANE_AW    = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/wr_control.sv
// Output-memory write controller for a systolic array: drives skewed per-column
// write enables and row addresses for one run of 2*width_height-1 steps.
module wr_control
    import wr_control_pkg::*;
#(
    parameter int width_height = WH_DEFAULT
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              active,
    input  logic [LANE_AW-1:0]                base_addr,
    output logic [width_height-1:0]           wr_en,
    output logic [width_height*LANE_AW-1:0]   wr_addr,
    output logic                              busy,
    output logic                              done
);

    localparam int KW = $clog2(2 * width_height - 1);
    localparam logic [KW-1:0] K_LAST = KW'(2 * width_height - 2);
    localparam logic [KW-1:0] K_ONE  = KW'(1);

    logic [1:0]                        state_r;
    logic [1:0]                        state_s;
    logic [KW-1:0]                     k_r;
    logic [KW-1:0]                     k_s;
    logic [LANE_AW-1:0]                base_r;
    logic [LANE_AW-1:0]                base_s;
    logic [31:0]                       k_ext_s;
    logic                              run_nx_s;
    logic [width_height-1:0]           lane_en_s;
    logic [width_height*LANE_AW-1:0]   lane_addr_s;

    // Next-state logic; outputs below are decoded from the next state so the
    // registered outputs line up with the step they describe.
    always_comb begin
        state_s = state_r;
        k_s     = k_r;
        base_s  = base_r;
        case (state_r)
            ST_IDLE: begin
                if (active) begin
                    state_s = ST_RUN;
                    k_s     = {KW{1'b0}};
                    base_s  = base_addr;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (k_r == K_LAST) begin
                    state_s = ST_DONE;
                end else begin
                    k_s = k_r + K_ONE;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
                k_s     = {KW{1'b0}};
            end
            default: begin
                state_s = ST_IDLE;
                k_s     = {KW{1'b0}};
            end
        endcase
    end

    assign k_ext_s  = 32'(k_s);
    assign run_nx_s = (state_s == ST_RUN);

    // Lane i is live while i <= k <= i+width_height-1; its row is k-i past the base.
    for (genvar gi = 0; gi < width_height; gi++) begin : g_lane
        assign lane_en_s[gi] = run_nx_s &&
                               (k_ext_s >= 32'(gi)) &&
                               (k_ext_s <= 32'(gi + width_height - 1));
        assign lane_addr_s[gi*LANE_AW +: LANE_AW] =
            lane_en_s[gi] ? (base_s + LANE_AW'(k_ext_s - 32'(gi))) : {LANE_AW{1'b0}};
    end

    // State, step counter, latched base and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            k_r     <= {KW{1'b0}};
            base_r  <= {LANE_AW{1'b0}};
            wr_en   <= {width_height{1'b0}};
            wr_addr <= {(width_height*LANE_AW){1'b0}};
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_r <= state_s;
            k_r     <= k_s;
            base_r  <= base_s;
            wr_en   <= lane_en_s;
            wr_addr <= lane_addr_s;
            busy    <= run_nx_s;
            done    <= (state_s == ST_DONE);
        end
    end

endmodule

// File: doc/wr_control.md
WR_CONTROL -- requirements
Module: wr_control

Interface
REQ-001 SHALL have parameter: width_height, 16, systolic array dimension and lane count (legal range 2..64).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: active  input  1  start request from the read-side controller's write-activate output.
REQ-005 SHALL have port: base_addr  input  8  output-memory base row for the run, latched at start.
REQ-006 SHALL have port: wr_en  output  width_height  per-lane output-memory write enable; bit i = column i.
REQ-007 SHALL have port: wr_addr  output  width_height*8  per-lane write row; lane i in bits [8i+7:8i].
REQ-008 SHALL have port: busy  output  1  high while a run is in progress.
REQ-009 SHALL have port: done  output  1  one-cycle pulse after the last lane write.

Function
REQ-010 SHALL implement FSM with states IDLE, RUN, DONE; all outputs registered.
REQ-011 SHALL sample active only in IDLE; active=1 in IDLE -> RUN next cycle, base_addr latched, step counter k=0.
REQ-012 SHALL advance k by 1 each RUN cycle; k width $clog2(2*width_height-1).
REQ-013 SHALL, in RUN, drive wr_en[i]=1 iff i <= k <= i+width_height-1 (diagonal skew: one-hot fill from LSB, drain from LSB).
REQ-014 SHALL drive lane i address = latched base + (k - i) mod 256 when wr_en[i]=1, else 8'h00.
REQ-015 SHALL leave RUN after k = 2*width_height-2 -> DONE; each lane writes exactly width_height rows.
REQ-016 SHALL, in DONE, drive wr_en=0, wr_addr=0, busy=0, done=1 for exactly one cycle, then IDLE.
REQ-017 SHALL hold busy=1 in every RUN cycle, 0 otherwise.
REQ-018 SHALL ignore active in RUN and DONE; no queuing of requests.
REQ-019 SHALL ignore base_addr changes after latching; new value used only at the next start.
REQ-020 SHALL wrap lane addresses modulo 256 without error indication.
REQ-021 SHALL hold active continuously -> next run starts in RUN two cycles after the done pulse (DONE -> IDLE -> RUN).

Reset
REQ-022 SHALL, on reset=1, immediately (asynchronously) force state IDLE, k=0, latched base=0, wr_en=0, wr_addr=0, busy=0, done=0.
REQ-023 SHALL abort any run in progress on reset, without a done pulse; after reset release, a fresh active starts at k=0.
REQ-024 SHALL ignore active while reset=1.

Structure
REQ-025 SHALL place in the shared package: default width_height, lane address width (8), and FSM state encoding.
REQ-026 SHALL have no sub-module; per-lane enable and address decode generated by a loop over lanes from k and the latched base.
REQ-027 SHALL be synthesizable for any legal width_height with no width-specific constants (no hard-coded 16-bit literals).

Verification (width_height=16)
REQ-028 SHALL verify basic run: base=0x00, active pulse sampled at cycle 0 -> cycle 1 wr_en=0x0001, lane0=0x00; cycle 16 wr_en=0xFFFF, lane0=0x0F, lane15=0x00; cycle 31 wr_en=0x8000, lane15=0x0F; cycle 32 wr_en=0, done=1; cycle 33 busy=0.
REQ-029 SHALL verify wrap: base=0xF8 -> lane0 address 0x00 at k=8, 0x07 at k=15; lane3 address 0xFF at k=10.
REQ-030 SHALL verify mid-run reset: reset asserted at k=5 -> wr_en, wr_addr, busy 0 before next clock edge; done never pulses; new active after release -> wr_en=0x0001, k=0.
REQ-031 SHALL verify ignored inputs: extra active pulses at k=3 and k=20 plus base_addr change to 0x40 at k=2 -> run identical to REQ-028; single done pulse.
REQ-032 SHALL verify back-to-back: active held high -> first done at cycle 32, second run wr_en=0x0001 at cycle 34, second done at cycle 65.
REQ-033 SHALL verify per-lane write count: every lane asserts wr_en exactly 16 cycles per run, with addresses base..base+15 in increasing order.
